// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetches, feeds IF/ID with zero
// added latency, parks a stalled instruction and drains a stale request on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_Out,
  output logic [31:0] Instr_Out,
  output logic        we_IF_ID,
  output logic        rst_IF_ID
);

  // state | meaning
  // REQ   | request at pc outstanding; ack delivers straight into IF/ID
  // HOLD  | instruction for pc parked in held, waiting for stall to clear
  // DRAIN | stale request at pc still in flight; pending holds the new target
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pending, pending_nxt;
  logic [31:0] held, held_nxt;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign target = redirect_pc & WORD_MASK;
  assign pc_inc = pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_REQ;
      pc      <= RESET_PC & WORD_MASK;
      pending <= 32'h0;
      held    <= 32'h0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pending <= pending_nxt;
      held    <= held_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pending_nxt = pending;
    held_nxt    = held;
    imem_req    = 1'b0;
    we_IF_ID    = 1'b0;
    rst_IF_ID   = 1'b0;
    PC_Out      = 32'h0;
    Instr_Out   = 32'h0;

    case (state)
      S_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          rst_IF_ID = 1'b1;
          if (imem_ack) begin
            pc_nxt = target;
          end else begin
            pending_nxt = target;
            state_nxt   = S_DRAIN;
          end
        end else if (imem_ack) begin
          if (stall) begin
            held_nxt  = imem_rdata;
            state_nxt = S_HOLD;
          end else begin
            we_IF_ID  = 1'b1;
            PC_Out    = pc;
            Instr_Out = imem_rdata;
            pc_nxt    = pc_inc;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          rst_IF_ID = 1'b1;
          pc_nxt    = target;
          state_nxt = S_REQ;
        end else if (!stall) begin
          we_IF_ID  = 1'b1;
          PC_Out    = pc;
          Instr_Out = held;
          pc_nxt    = pc_inc;
          state_nxt = S_REQ;
        end
      end

      S_DRAIN: begin
        // pc is left untouched here so imem_addr keeps pointing at the stale request
        imem_req = 1'b1;
        if (redirect) begin
          rst_IF_ID = 1'b1;
          if (imem_ack) begin
            pc_nxt    = target;
            state_nxt = S_REQ;
          end else begin
            pending_nxt = target;
          end
        end else if (imem_ack) begin
          pc_nxt    = pending;
          state_nxt = S_REQ;
        end
      end

      default: begin
        state_nxt = S_REQ;
      end
    endcase

    if (rst) begin
      imem_req  = 1'b0;
      we_IF_ID  = 1'b0;
      rst_IF_ID = 1'b0;
      PC_Out    = 32'h0;
      Instr_Out = 32'h0;
    end
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/hold, redirect drain, wrap and async reset.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] PC_Out;
  logic [31:0] Instr_Out;
  logic        we_IF_ID;
  logic        rst_IF_ID;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .PC_Out(PC_Out), .Instr_Out(Instr_Out), .we_IF_ID(we_IF_ID), .rst_IF_ID(rst_IF_ID)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Puts the DUT in reset and returns at a falling edge with reset released.
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // Acks n fetches back to back without checking (setup only).
  task automatic prime(input int n, input logic [31:0] start);
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'b1; imem_rdata = (start + 32'(i * 4)) ^ 32'hA5A5_A5A5;
      @(negedge clk);
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    vectors++; if (we_IF_ID !== 1'b0) begin miscompares++; $display("FAIL reset_we got=%0b exp=0", we_IF_ID); end
    vectors++; if (Instr_Out !== 32'h0) begin miscompares++; $display("FAIL reset_instr got=%h exp=0", Instr_Out); end
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0; #1;
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL post_reset_req got=%0b exp=1", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL post_reset_addr got=%h exp=0", imem_addr); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      imem_ack = 1'b1; imem_rdata = exp_pc ^ 32'hA5A5_A5A5; #1;
      vectors++; if (imem_addr !== exp_pc) begin miscompares++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, imem_addr, exp_pc); end
      vectors++; if (we_IF_ID !== 1'b1) begin miscompares++; $display("FAIL stream_we[%0d] got=%0b exp=1", i, we_IF_ID); end
      vectors++; if (PC_Out !== exp_pc) begin miscompares++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, PC_Out, exp_pc); end
      vectors++; if (Instr_Out !== (exp_pc ^ 32'hA5A5_A5A5)) begin miscompares++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, Instr_Out, exp_pc ^ 32'hA5A5_A5A5); end
      @(negedge clk);
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_stall_hold();
    do_reset();
    prime(2, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678; stall = 1'b1; #1;
    vectors++; if (we_IF_ID !== 1'b0) begin miscompares++; $display("FAIL stall_ack_we got=%0b exp=0", we_IF_ID); end
    vectors++; if (imem_addr !== 32'h8) begin miscompares++; $display("FAIL stall_ack_addr got=%h exp=8", imem_addr); end
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'hFFFF_0000;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL hold_req[%0d] got=%0b exp=0", i, imem_req); end
      vectors++; if (we_IF_ID !== 1'b0) begin miscompares++; $display("FAIL hold_we[%0d] got=%0b exp=0", i, we_IF_ID); end
      vectors++; if (PC_Out !== 32'h0) begin miscompares++; $display("FAIL hold_idle_pc[%0d] got=%h exp=0", i, PC_Out); end
      @(negedge clk);
    end
    stall = 1'b0; #1;
    vectors++; if (we_IF_ID !== 1'b1) begin miscompares++; $display("FAIL release_we got=%0b exp=1", we_IF_ID); end
    vectors++; if (PC_Out !== 32'h8) begin miscompares++; $display("FAIL release_pc got=%h exp=8", PC_Out); end
    vectors++; if (Instr_Out !== 32'h1234_5678) begin miscompares++; $display("FAIL release_instr got=%h exp=12345678", Instr_Out); end
    @(negedge clk); #1;
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL next_req got=%0b exp=1", imem_req); end
    vectors++; if (imem_addr !== 32'hC) begin miscompares++; $display("FAIL next_addr got=%h exp=c", imem_addr); end
    @(negedge clk);
  endtask

  task automatic test_redirect_drain();
    do_reset();
    prime(4, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h103; #1;
    vectors++; if (rst_IF_ID !== 1'b1) begin miscompares++; $display("FAIL redir_flush got=%0b exp=1", rst_IF_ID); end
    vectors++; if (we_IF_ID !== 1'b0) begin miscompares++; $display("FAIL redir_we got=%0b exp=0", we_IF_ID); end
    vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL redir_addr got=%h exp=10", imem_addr); end
    @(negedge clk);
    redirect = 1'b0; redirect_pc = 32'h0; #1;
    vectors++; if (rst_IF_ID !== 1'b0) begin miscompares++; $display("FAIL drain_flush got=%0b exp=0", rst_IF_ID); end
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL drain_req got=%0b exp=1", imem_req); end
    vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL drain_addr got=%h exp=10", imem_addr); end
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; stall = 1'b1; #1;
    vectors++; if (we_IF_ID !== 1'b0) begin miscompares++; $display("FAIL drain_ack_we got=%0b exp=0", we_IF_ID); end
    vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL drain_ack_addr got=%h exp=10", imem_addr); end
    @(negedge clk);
    imem_ack = 1'b0; stall = 1'b0; #1;
    vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL drain_target got=%h exp=100", imem_addr); end
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL drain_target_req got=%0b exp=1", imem_req); end
    @(negedge clk);
  endtask

  task automatic test_redirect_in_hold();
    do_reset();
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013; stall = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h42; #1;
    vectors++; if (rst_IF_ID !== 1'b1) begin miscompares++; $display("FAIL hold_redir_flush got=%0b exp=1", rst_IF_ID); end
    vectors++; if (we_IF_ID !== 1'b0) begin miscompares++; $display("FAIL hold_redir_we got=%0b exp=0", we_IF_ID); end
    @(negedge clk);
    redirect = 1'b0; stall = 1'b0; #1;
    vectors++; if (imem_addr !== 32'h40) begin miscompares++; $display("FAIL hold_redir_addr got=%h exp=40", imem_addr); end
    vectors++; if (we_IF_ID !== 1'b0) begin miscompares++; $display("FAIL hold_redir_stale_we got=%0b exp=0", we_IF_ID); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
    vectors++; if (we_IF_ID !== 1'b0) begin miscompares++; $display("FAIL wrap_redir_we got=%0b exp=0", we_IF_ID); end
    @(negedge clk);
    redirect = 1'b0; imem_rdata = 32'h0000_0093; #1;
    vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
    vectors++; if (PC_Out !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pc got=%h exp=fffffffc", PC_Out); end
    vectors++; if (Instr_Out !== 32'h0000_0093) begin miscompares++; $display("FAIL wrap_instr got=%h exp=93", Instr_Out); end
    @(negedge clk);
    imem_ack = 1'b0; #1;
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next got=%h exp=0", imem_addr); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    prime(1, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA; #1;
    vectors++; if (we_IF_ID !== 1'b1) begin miscompares++; $display("FAIL pre_areset_we got=%0b exp=1", we_IF_ID); end
    #2 rst = 1'b1; #1;
    vectors++; if (we_IF_ID !== 1'b0) begin miscompares++; $display("FAIL areset_we got=%0b exp=0", we_IF_ID); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL areset_req got=%0b exp=0", imem_req); end
    vectors++; if (Instr_Out !== 32'h0) begin miscompares++; $display("FAIL areset_instr got=%h exp=0", Instr_Out); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL areset_addr got=%h exp=0", imem_addr); end
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0; #1;
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL areset_release_addr got=%h exp=0", imem_addr); end
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL areset_release_req got=%0b exp=1", imem_req); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect_drain();
    test_redirect_in_hold();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hazard hold: the IF/ID register must not load this cycle.
REQ-005 redirect  input  1  branch/jump taken: refetch from redirect_pc and flush IF/ID.
REQ-006 redirect_pc  input  32  target address; bits [1:0] ignored.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  32  word-aligned fetch address, bits [1:0] always 0.
REQ-009 imem_ack  input  1  memory response valid; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 PC_Out  output  32  PC of the instruction presented to IF/ID.
REQ-012 Instr_Out  output  32  instruction presented to IF/ID.
REQ-013 we_IF_ID  output  1  IF/ID load enable, one cycle per delivered instruction.
REQ-014 rst_IF_ID  output  1  IF/ID flush (bubble insert).

Function
REQ-015 The block SHALL hold state in one of REQ, HOLD or DRAIN, plus a 32-bit pc, a 32-bit pending pc and a 32-bit held-instruction register.
REQ-016 In REQ and DRAIN, imem_req SHALL be 1; in HOLD it SHALL be 0. imem_addr SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-017 PC_Out, Instr_Out, we_IF_ID and rst_IF_ID SHALL be combinational from the current state and inputs, so IF/ID captures them at the same clock edge; fetch-to-IF/ID latency is 0 cycles after ack.
REQ-018 REQ, imem_ack=1, stall=0, redirect=0: we_IF_ID=1, PC_Out=pc, Instr_Out=imem_rdata; pc<=pc+4; stay in REQ (back-to-back fetch).
REQ-019 REQ, imem_ack=1, stall=1, redirect=0: we_IF_ID=0; held<=imem_rdata; go to HOLD.
REQ-020 HOLD, stall=0, redirect=0: we_IF_ID=1, PC_Out=pc, Instr_Out=held; pc<=pc+4; go to REQ. In HOLD with stall=1, outputs stay idle and state is unchanged.
REQ-021 redirect=1 SHALL take priority over stall and ack and SHALL assert rst_IF_ID=1 and we_IF_ID=0 that cycle.
REQ-022 The redirect target SHALL be {redirect_pc[31:2],2'b00}.
REQ-023 Redirect in HOLD, or in REQ with imem_ack=1: discard the data, set pc<=target, go to REQ.
REQ-024 Redirect in REQ with imem_ack=0: pending<=target, go to DRAIN while keeping the old imem_addr.
REQ-025 DRAIN, imem_ack=1: discard the data, set pc<=pending, go to REQ. A further redirect in DRAIN SHALL overwrite pending, and rst_IF_ID=1 again.
REQ-026 In DRAIN, we_IF_ID SHALL be 0 regardless of stall.
REQ-027 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4=0).
REQ-028 When we_IF_ID=0 and rst_IF_ID=0, PC_Out and Instr_Out SHALL be 0.

Reset
REQ-029 rst=1 SHALL immediately force state=REQ, pc=RESET_PC, pending=0 and held=0, without waiting for clk.
REQ-030 While rst=1, imem_req, we_IF_ID, rst_IF_ID, PC_Out and Instr_Out SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon any outstanding request.
REQ-032 The memory SHALL tolerate imem_req dropping without an ack.
REQ-033 After rst deasserts, the first request SHALL issue at RESET_PC.

Verification
REQ-034 Streaming: reset, memory ack every cycle with rdata=addr^32'hA5A5_A5A5 -> we_IF_ID=1 each cycle, PC_Out=0,4,8,12, Instr_Out matches.
REQ-035 Stall on ack: stall=1 for 3 cycles at pc=8, ack with 32'h1234_5678 -> HOLD, imem_req=0; on release we_IF_ID=1, PC_Out=8, Instr_Out=32'h1234_5678, next fetch at 12.
REQ-036 Redirect with ack 2 cycles late: redirect at pc=16 to 32'h103 -> rst_IF_ID=1 one cycle, imem_addr stays 16 until ack, data discarded, next imem_addr=32'h100.
REQ-037 Redirect with stall together in HOLD -> rst_IF_ID=1, we_IF_ID=0, fetch from target.
REQ-038 Wrap: redirect to 32'hFFFF_FFFC, ack -> PC_Out=32'hFFFF_FFFC, next imem_addr=0.
REQ-039 Async reset asserted mid-WAIT, between clock edges -> outputs 0 immediately; after release, imem_addr=RESET_PC.
